// File: rtl/d_ff_pipe_pkg.sv
// Shared constants and helpers for the d_ff_pipe register pipeline.
package d_ff_pipe_pkg;

    localparam int D_FF_PIPE_WIDTH_DEF = 8;
    localparam int D_FF_PIPE_DEPTH_DEF = 4;

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_ff_pipe_stage.sv
// One pipeline stage: a {valid, data} register with its slice of the ready chain.
module d_ff_pipe_stage
    import d_ff_pipe_pkg::*;
#(
    parameter int            SW      = D_FF_PIPE_WIDTH_DEF,
    parameter logic [SW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          rdy_next,
    input  logic          in_valid,
    input  logic [SW-1:0] in_data,
    output logic          rdy,
    output logic          valid,
    output logic [SW-1:0] data
);

    logic          valid_q, valid_d;
    logic [SW-1:0] data_q, data_d;

    // An empty stage always accepts, so bubbles collapse under a downstream stall.
    assign rdy   = ~valid_q | rdy_next;
    assign valid = valid_q;
    assign data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (rdy) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/d_ff_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready register pipeline with flush and occupancy count.
// Define D_FF_PIPE_PARITY_EN to carry an even-parity bit per stage and flag output errors.
module d_ff_pipe
    import d_ff_pipe_pkg::*;
#(
    parameter int               WIDTH   = D_FF_PIPE_WIDTH_DEF,
    parameter int               DEPTH   = D_FF_PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      out_par_err
);

    localparam int CW = cnt_w(DEPTH);

`ifdef D_FF_PIPE_PARITY_EN
    localparam int              PW     = 1;
    localparam logic [WIDTH:0]  SRST   = {^RST_VAL, RST_VAL};
`else
    localparam int              PW     = 0;
    localparam logic [WIDTH-1:0] SRST  = RST_VAL;
`endif
    localparam int SW = WIDTH + PW;

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] rdy_v;
    logic [SW-1:0]    dat [DEPTH];
    logic [SW-1:0]    in_word;
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    count_q, count_d;

`ifdef D_FF_PIPE_PARITY_EN
    assign in_word = {^in_data, in_data};
`else
    assign in_word = in_data;
`endif

    assign in_ready = rdy_v[0] & ~flush & ~rst;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = vld[DEPTH-1] & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic          src_valid;
        logic [SW-1:0] src_data;
        logic          nxt_rdy;

        if (i == 0) begin : g_first
            assign src_valid = in_xfer;
            assign src_data  = in_word;
        end else begin : g_mid
            assign src_valid = vld[i-1];
            assign src_data  = dat[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign nxt_rdy = out_ready;
        end else begin : g_inner
            assign nxt_rdy = rdy_v[i+1];
        end

        d_ff_pipe_stage #(
            .SW      (SW),
            .RST_VAL (SRST)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .rdy_next (nxt_rdy),
            .in_valid (src_valid),
            .in_data  (src_data),
            .rdy      (rdy_v[i]),
            .valid    (vld[i]),
            .data     (dat[i])
        );
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1][WIDTH-1:0];

`ifdef D_FF_PIPE_PARITY_EN
    // Reduction over {par, data} equals ^data ^ par.
    assign out_par_err = out_valid & (^dat[DEPTH-1]);
`else
    assign out_par_err = 1'b0;
`endif

    // A delivery in a flush cycle still leaves the count at zero.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_d_ff_pipe.sv
// Directed and random checks of d_ff_pipe against a word-position reference model.
module tb_d_ff_pipe;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          out_par_err;

  always #5 clk = ~clk;

  d_ff_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL('0)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .out_par_err (out_par_err)
  );

  int checks = 0;
  int errors = 0;

  // Model: words in flight, oldest first, each with its stage position.
  int           pos_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out = '0;
  bit           known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic fl, input logic iv,
                       input logic [W-1:0] id, input logic orr);
    int           npos[$];
    logic [W-1:0] ndat[$];
    logic [W-1:0] nlast;
    bit           prev_moved;
    bit           moved;
    bit           exp_rdy;
    int           prev_old;
    int           p;
    rst = r; flush = fl; in_valid = iv; in_data = id; out_ready = orr;
    @(negedge clk);
    nlast = last_out; prev_moved = 1'b0; prev_old = 0; moved = 1'b0;
    for (int k = 0; k < pos_q.size(); k++) begin
      p = pos_q[k];
      if (k == 0) moved = (p == D - 1) ? orr : 1'b1;
      else        moved = (p + 1 < prev_old) || prev_moved;
      prev_old = p;
      prev_moved = moved;
      if (!(moved && p == D - 1)) begin
        if (moved) begin
          p = p + 1;
          if (p == D - 1) nlast = exp_q[k];
        end
        npos.push_back(p);
        ndat.push_back(exp_q[k]);
      end
    end
    exp_rdy = !r && !fl && (pos_q.size() == 0 || pos_q[$] > 0 || moved);
    chk("in_ready", in_ready, exp_rdy);
    if (known) begin
      chk("out_valid", out_valid, (pos_q.size() > 0 && pos_q[0] == D - 1));
      chk("out_data", out_data, last_out);
      chk("count", count, pos_q.size());
      chk("out_par_err", out_par_err, 1'b0);
    end
    @(posedge clk);
    if (r) begin
      pos_q.delete(); exp_q.delete(); last_out = '0; known = 1'b1;
    end else if (fl) begin
      pos_q.delete(); exp_q.delete();
    end else begin
      pos_q = npos; exp_q = ndat; last_out = nlast;
      if (iv && exp_rdy) begin
        pos_q.push_back(0);
        exp_q.push_back(id);
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset with active input
    cycle(1, 0, 1, 8'hA5, 0);
    cycle(1, 0, 1, 8'hA5, 0);

    // Back-to-back stream with out_ready held
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, W'(i), 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'h00, 1);

    // Fill under stall, then release one cycle with new input
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, W'(8'h30 + i), 0);
    cycle(0, 0, 1, 8'h40, 0);
    cycle(0, 0, 1, 8'h41, 1);
    cycle(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'h00, 1);

    // Bubble between two words collapses under stall
    cycle(0, 0, 1, 8'h11, 0);
    cycle(0, 0, 0, 8'h00, 0);
    cycle(0, 0, 1, 8'h22, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 8'h00, 1);

    // Flush with three words in flight and simultaneous input
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, W'(8'h50 + i), 0);
    cycle(0, 1, 1, 8'h55, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 8'h00, 1);

    // Reset wins over flush
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, W'(8'h60 + i), 0);
    cycle(1, 1, 1, 8'h66, 1);
    cycle(0, 0, 0, 8'h00, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 8'h00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
